// File: rtl/spram_pkg.sv
// spram_pkg: shared geometry for the FIFO controller, its single-port RAM and benches.
package spram_pkg;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 2 ** AW;
endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// spram_fifo_ctrl_if: producer/consumer streams plus the single-port RAM bus of the FIFO controller.
interface spram_fifo_ctrl_if #(
    parameter int DW = spram_pkg::DW,
    parameter int AW = spram_pkg::AW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_we;
    modport slave (
        input  in_valid, in_data, out_ready, ram_dout,
        output in_ready, out_valid, out_data, ram_addr, ram_din, ram_we
    );
    modport master (
        output in_valid, in_data, out_ready, ram_dout,
        input  in_ready, out_valid, out_data, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/spram_fifo_ctrl_ptr_wrap.sv
// ptr_wrap: AW-bit incrementing pointer that wraps naturally, with synchronous clear.
module ptr_wrap #(
    parameter int AW = spram_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [AW-1:0] ptr
);
    always_ff @(posedge clk)
        if (rst) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: FIFO over one single-port RAM with a registered head word.
// Reads win the shared port; the writer takes every cycle without a read issue.
module spram_fifo_ctrl #(
    parameter int DW = spram_pkg::DW,
    parameter int AW = spram_pkg::AW
) (
    input  logic                   clk,
    input  logic                   rst,
    spram_fifo_ctrl_if.slave       bus,
    output logic [AW:0]            level,
    output logic                   full,
    output logic                   empty
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   mem_count;
    logic          rd_pend;
    logic          rd_issue;
    logic          wr_en;
    assign rd_issue = mem_count != '0 && !rd_pend && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = !rst && mem_count < DEPTH_W && !rd_issue;
    assign wr_en = bus.in_valid && bus.in_ready;
    assign bus.ram_we = wr_en;
    assign bus.ram_addr = rd_issue ? rd_ptr : wr_ptr;
    assign bus.ram_din = bus.in_data;
    assign level = mem_count + (AW + 1)'(rd_pend) + (AW + 1)'(bus.out_valid);
    assign full = mem_count == DEPTH_W;
    assign empty = level == '0;
    ptr_wrap #(.AW(AW)) u_wr_ptr (.clk(clk), .rst(rst), .inc(wr_en), .ptr(wr_ptr));
    ptr_wrap #(.AW(AW)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_issue), .ptr(rd_ptr));
    // rd_pend marks the cycle RAM data arrives; reset drops it so no stale load follows.
    always_ff @(posedge clk)
        if (rst) begin
            mem_count     <= '0;
            rd_pend       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            mem_count <= wr_en ? mem_count + 1'b1 : rd_issue ? mem_count - 1'b1 : mem_count;
            rd_pend   <= rd_issue;
            if (rd_pend) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.ram_dout;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb_spram_fifo_ctrl: scoreboard bench for spram_fifo_ctrl with a behavioural single-port RAM.
module tb_spram_fifo_ctrl;
    localparam int DW = spram_pkg::DW;
    localparam int AW = spram_pkg::AW;
    localparam int DEPTH = spram_pkg::DEPTH;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW:0] level;
    logic full;
    logic empty;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q [$];
    logic [DW-1:0] hold_d;
    logic stall = 1'b0;
    logic done;
    int checks = 0;
    int errors = 0;
    int pops = 0;
    int pops0;
    int acc;
    int n;
    spram_fifo_ctrl_if bus ();
    spram_fifo_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .level(level), .full(full), .empty(empty));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Scoreboard: pushes on accepted writes, pops on consumed outputs; level must equal its depth.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall = 1'b0;
        end else begin
            check("level", 32'(level), q.size());
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("we", 32'(bus.ram_we), 32'(bus.in_valid && bus.in_ready));
            if (stall) begin
                check("hold_v", 32'(bus.out_valid), 1);
                check("hold_d", 32'(bus.out_data), 32'(hold_d));
            end
            if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("underflow", 1, 0);
                else begin
                    check("data", 32'(bus.out_data), 32'(q.pop_front()));
                    pops++;
                end
            end
            stall = bus.out_valid && !bus.out_ready;
            hold_d = bus.out_data;
        end
    end
    task automatic sync();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [DW-1:0] d);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) check("push_timeout", 0, 1);
        sync();
        bus.in_valid = 1'b0;
    endtask
    task automatic drain();
        int k = 0;
        while (level != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", 32'(level), 0);
        sync();
    endtask
    task automatic do_reset();
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
    endtask
    initial begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'hEE;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_we", 32'(bus.ram_we), 0);
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        sync();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        // First word reaches the output register two cycles after its write.
        push(8'hA1);
        @(negedge clk);
        check("a1_lat0", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("a1_lat1", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("a1_lat2", 32'(bus.out_valid), 1);
        check("a1_data", 32'(bus.out_data), 32'h A1);
        sync();
        push(8'hB2);
        push(8'hC3);
        repeat (2) @(negedge clk);
        check("abc_level", 32'(level), 3);
        check("abc_head", 32'(bus.out_data), 32'hA1);
        do_reset();
        for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
        bus.in_valid = 1'b1;
        bus.in_data = 8'h19;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 32'(bus.in_ready), 0);
            check("full_flag", 32'(full), 1);
            check("full_level", 32'(level), 9);
            check("full_head", 32'(bus.out_data), 32'h10);
        end
        sync();
        bus.in_valid = 1'b0;
        pops0 = pops;
        bus.out_ready = 1'b1;
        drain();
        check("drain_pops", pops - pops0, 9);
        check("drain_empty", 32'(empty), 1);
        check("drain_full", 32'(full), 0);
        // Steady stream: writes and reads alternate on the single port.
        bus.in_valid = 1'b1;
        bus.in_data = 8'h40;
        acc = 0;
        pops0 = pops;
        for (int i = 0; i < 40; i++) begin
            bit a;
            @(negedge clk);
            check("alt_in_ready", 32'(bus.in_ready), 32'(i % 2 == 0));
            a = bus.in_ready;
            if (a) acc++;
            sync();
            if (a) bus.in_data = bus.in_data + 1'b1;
        end
        bus.in_valid = 1'b0;
        drain();
        check("stream_acc", acc, 20);
        check("stream_pops", pops - pops0, 20);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
        bus.out_ready = 1'b1;
        @(negedge clk);
        sync();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_level", 32'(level), 5);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_we", 32'(bus.ram_we), 0);
        sync();
        pops0 = pops;
        bus.out_ready = 1'b1;
        push(8'h5A);
        drain();
        check("after_rst_pops", pops - pops0, 1);
        bus.out_ready = 1'b0;
        pops0 = pops;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
                done = 1'b1;
            end
            begin
                n = 0;
                while (!(done && level == 0) && n < 300) begin
                    sync();
                    bus.out_ready = !bus.out_ready;
                    n++;
                end
            end
        join
        check("toggle_level", 32'(level), 0);
        check("toggle_pops", pops - pops0, 8);
        check("final_q", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
